dmem_responder: RTL

Data-memory responder: the memory-side end of the hart's `dmem` port, replacing the combinational data memory with a multi-cycle slave. It accepts one word-aligned read or write request, masked by byte lanes, from the hart. After a fixed `LATENCY` it returns read data, or a write acknowledgement, with a one-cycle `o_dmem_valid` pulse. It also flags out-of-range, unaligned and illegal requests. It sits beside the hart's memory stage in the testbench/SoC top and owns the data array.

---
 rtl/dmem_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave for the hart's dmem port.
// One request is captured in IDLE, held for LATENCY cycles, then answered
// with a single-cycle valid strobe. The array is updated or read on the
// edge that enters RESP, using the request being answered.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_busy,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_err
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_mask;
    logic        cap_wr;
    logic        cap_err;

    logic [31:0] mem [DEPTH_WORDS];

    logic        req;
    logic        req_err;
    logic        enter_resp;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_mask;
    logic        acc_wr;
    logic        acc_err;
    logic [31:0] acc_off;
    logic [AW-1:0] idx;
    logic [31:0] bmask;

    // Request decode, error classification and selection of the request being
    // answered: with LATENCY=1 the live inputs go straight to RESP, otherwise
    // the captured copy is used.
    always_comb begin
        req     = i_dmem_ren | i_dmem_wen;
        req_err = (i_dmem_ren & i_dmem_wen)
                | (i_dmem_addr[1:0] != 2'b00)
                | ({1'b0, i_dmem_addr} < {1'b0, BASE_ADDR})
                | ({1'b0, i_dmem_addr} >= LIMIT);

        enter_resp = ((state == S_IDLE) && req && (LATENCY == 1))
                   || ((state == S_WAIT) && (cnt == 4'd1));

        if (state == S_IDLE) begin
            acc_addr  = i_dmem_addr;
            acc_wdata = i_dmem_wdata;
            acc_mask  = i_dmem_mask;
            acc_wr    = i_dmem_wen;
            acc_err   = req_err;
        end else begin
            acc_addr  = cap_addr;
            acc_wdata = cap_wdata;
            acc_mask  = cap_mask;
            acc_wr    = cap_wr;
            acc_err   = cap_err;
        end

        acc_off = acc_addr - BASE_ADDR;
        idx     = AW'(acc_off >> 2);
        for (int k = 0; k < 4; k++) begin
            bmask[8*k +: 8] = {8{acc_mask[k]}};
        end
    end

    // Control FSM: capture in IDLE, count down in WAIT, one cycle of RESP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_mask  <= 4'd0;
            cap_wr    <= 1'b0;
            cap_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        cap_addr  <= i_dmem_addr;
                        cap_wdata <= i_dmem_wdata;
                        cap_mask  <= i_dmem_mask;
                        cap_wr    <= i_dmem_wen;
                        cap_err   <= req_err;
                        if (LATENCY == 1) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Byte-masked array write; errored or reset-aborted requests never land.
    always_ff @(posedge i_clk) begin
        if (!i_rst && enter_resp && acc_wr && !acc_err) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_mask[k]) mem[idx][8*k +: 8] <= acc_wdata[8*k +: 8];
            end
        end
    end

    // Response registers, loaded only on the edge entering RESP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dmem_rdata <= 32'd0;
            o_dmem_err   <= 1'b0;
        end else if (enter_resp) begin
            o_dmem_err <= acc_err;
            if (acc_err)      o_dmem_rdata <= 32'd0;
            else if (!acc_wr) o_dmem_rdata <= mem[idx] & bmask;
        end
    end

    assign o_dmem_busy  = (state != S_IDLE);
    assign o_dmem_valid = (state == S_RESP);
endmodule
